// File: rtl/tcdm_bank_responder.sv
// ----------------------------------------------------------------------------
// tcdm_bank_responder
//
// Memory-side responder for a multi-port TCDM request/grant/rvalid protocol.
// Models one shared, word-addressed 32-bit SRAM bank. At most one port is
// granted per cycle by a round-robin arbiter. The response (rvalid/rdata)
// comes back exactly one cycle after the grant. A programmable number of
// idle cycles can follow every grant, which produces staggered grant
// patterns for exercising upstream gathering logic.
//
// Ports:
//   clk_i       clock
//   rst_ni      asynchronous active-low reset
//   gap_i       idle cycles inserted after each grant (sampled at the grant edge)
//   req_i       per-port request
//   add_i       per-port byte address; word index is add_i[ADDR_W+1:2]
//   wen_i       per-port write enable, active-low (1 = read, 0 = write)
//   be_i        per-port byte enables (writes only)
//   wdata_i     per-port write data
//   gnt_o       per-port grant, combinational, one-hot or zero
//   rvalid_o    per-port response valid, registered 1-cycle pulse
//   rdata_o     per-port read data, registered, held between responses
//   busy_cnt_o  saturating count of cycles with a pending request but no grant
// ----------------------------------------------------------------------------
module tcdm_bank_responder #(
    parameter int NB_PORTS = 8,
    parameter int ADDR_W   = 10,
    parameter int GAP_W    = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [GAP_W-1:0]              gap_i,
    input  logic [NB_PORTS-1:0]           req_i,
    input  logic [NB_PORTS-1:0][31:0]     add_i,
    input  logic [NB_PORTS-1:0]           wen_i,
    input  logic [NB_PORTS-1:0][3:0]      be_i,
    input  logic [NB_PORTS-1:0][31:0]     wdata_i,
    output logic [NB_PORTS-1:0]           gnt_o,
    output logic [NB_PORTS-1:0]           rvalid_o,
    output logic [NB_PORTS-1:0][31:0]     rdata_o,
    output logic [15:0]                   busy_cnt_o
);

    localparam int PTR_W = (NB_PORTS > 1) ? $clog2(NB_PORTS) : 1;
    localparam int DEPTH = 2 ** ADDR_W;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [PTR_W-1:0]             rr_ptr_q,   rr_ptr_d;
    logic [GAP_W-1:0]             gap_cnt_q,  gap_cnt_d;
    logic [NB_PORTS-1:0]          rvalid_q,   rvalid_d;
    logic [NB_PORTS-1:0][31:0]    rdata_q,    rdata_d;
    logic [15:0]                  busy_cnt_q, busy_cnt_d;

    logic [31:0]                  mem_q [DEPTH];

    // ------------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------------
    logic               win_found;
    logic [PTR_W-1:0]   win_idx;
    logic [PTR_W-1:0]   cand;
    int unsigned        cand_ext;
    logic               grant_en;
    logic [ADDR_W-1:0]  win_word;

    // NOTE: every variable assigned in an always_comb gets a default at the
    // top of the block; a path that skips an assignment would infer a latch.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        cand_ext  = 0;
        // Search upward from rr_ptr and wrap; the first requester found wins.
        for (int i = 0; i < NB_PORTS; i++) begin
            cand_ext = int'(rr_ptr_q) + i;
            if (cand_ext >= NB_PORTS) begin
                cand_ext = cand_ext - NB_PORTS;
            end
            cand = PTR_W'(cand_ext);
            if (!win_found && req_i[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Grants are suppressed while reset is asserted so gnt_o reads zero then,
    // and so no write can reach the bank during reset.
    assign grant_en = rst_ni && (gap_cnt_q == '0) && win_found;
    assign win_word = add_i[win_idx][ADDR_W+1:2];

    always_comb begin
        gnt_o = '0;
        if (grant_en) begin
            gnt_o[win_idx] = 1'b1;
        end
    end

    // Address bits outside the word index are deliberately ignored, which
    // makes addresses alias modulo the bank size.
    logic unused_add_bits;
    always_comb begin
        unused_add_bits = 1'b0;
        for (int p = 0; p < NB_PORTS; p++) begin
            unused_add_bits = unused_add_bits ^ (^add_i[p]);
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        gap_cnt_d  = gap_cnt_q;
        busy_cnt_d = busy_cnt_q;
        rvalid_d   = '0;
        rdata_d    = rdata_q;

        // gap_cnt counts down unconditionally; gap_i only matters at a grant.
        if (gap_cnt_q != '0) begin
            gap_cnt_d = gap_cnt_q - 1'b1;
        end else if (grant_en) begin
            gap_cnt_d = gap_i;
        end

        if (grant_en) begin
            rr_ptr_d = (win_idx == PTR_W'(NB_PORTS - 1)) ? '0 : win_idx + 1'b1;
            rvalid_d[win_idx] = 1'b1;
            // The bank is read before this edge's write lands, so a read of
            // a word written one cycle earlier already sees the new data.
            rdata_d[win_idx]  = wen_i[win_idx] ? mem_q[win_word] : 32'h0;
        end

        if ((|req_i) && !grant_en && (busy_cnt_q != 16'hFFFF)) begin
            busy_cnt_d = busy_cnt_q + 16'd1;
        end
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its inputs regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q   <= '0;
            gap_cnt_q  <= '0;
            rvalid_q   <= '0;
            rdata_q    <= '0;
            busy_cnt_q <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            gap_cnt_q  <= gap_cnt_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    // NOTE: the bank array has no reset; an SRAM cannot be cleared in one
    // cycle and resetting it would turn it into a huge flop array.
    always_ff @(posedge clk_i) begin
        if (grant_en && !wen_i[win_idx]) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[win_idx][b]) begin
                    mem_q[win_word][8*b +: 8] <= wdata_i[win_idx][8*b +: 8];
                end
            end
        end
    end

    assign rvalid_o   = rvalid_q;
    assign rdata_o    = rdata_q;
    assign busy_cnt_o = busy_cnt_q;

endmodule

// File: tb/tb_tcdm_bank_responder.sv
// ----------------------------------------------------------------------------
// tb_tcdm_bank_responder
//
// Directed bench for tcdm_bank_responder. The stimulus process drives
// requests, checks grants in the request cycle and pushes the expected
// response (port, data, cycle) into a scoreboard queue. A separate monitor
// pops and compares whenever the DUT raises an rvalid bit.
// ----------------------------------------------------------------------------
module tb_tcdm_bank_responder;

    localparam int NB = 8;

    logic                 clk_i = 1'b0;
    logic                 rst_ni;
    logic [3:0]           gap_i;
    logic [NB-1:0]        req_i;
    logic [NB-1:0][31:0]  add_i;
    logic [NB-1:0]        wen_i;
    logic [NB-1:0][3:0]   be_i;
    logic [NB-1:0][31:0]  wdata_i;
    logic [NB-1:0]        gnt_o;
    logic [NB-1:0]        rvalid_o;
    logic [NB-1:0][31:0]  rdata_o;
    logic [15:0]          busy_cnt_o;

    tcdm_bank_responder #(
        .NB_PORTS (NB),
        .ADDR_W   (10),
        .GAP_W    (4)
    ) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .gap_i      (gap_i),
        .req_i      (req_i),
        .add_i      (add_i),
        .wen_i      (wen_i),
        .be_i       (be_i),
        .wdata_i    (wdata_i),
        .gnt_o      (gnt_o),
        .rvalid_o   (rvalid_o),
        .rdata_o    (rdata_o),
        .busy_cnt_o (busy_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        int          port;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Check gnt_o in the current cycle; port >= 0 queues the expected response.
    task automatic expect_gnt(input string name, input logic [7:0] exp, input int port,
                              input logic [31:0] rd);
        @(negedge clk_i);
        check(name, {24'h0, gnt_o}, {24'h0, exp});
        if (port >= 0) begin
            sb_q.push_back('{port: port, data: rd, cyc: cyc + 1});
        end
    endtask

    // One request on a single port; leaves the bench one cycle later with req cleared.
    task automatic single(input int p, input logic [31:0] addr, input logic wen,
                          input logic [3:0] be, input logic [31:0] wd,
                          input logic [31:0] rd, input string name);
        req_i      = '0;
        req_i[p]   = 1'b1;
        add_i[p]   = addr;
        wen_i[p]   = wen;
        be_i[p]    = be;
        wdata_i[p] = wd;
        expect_gnt(name, 8'(1 << p), p, rd);
        tick();
        req_i = '0;
    endtask

    // Monitor: compare every response against the scoreboard head.
    always @(negedge clk_i) begin
        if (rst_ni === 1'b1) begin
            for (int p = 0; p < NB; p++) begin
                if (rvalid_o[p] === 1'b1) begin
                    if (sb_q.size() == 0) begin
                        n_total++;
                        $display("FAIL unexpected_rvalid: port %0d rvalid at cycle %0d, expected none",
                                 p, cyc);
                    end else begin
                        mon_e = sb_q.pop_front();
                        check("rsp_port",  p,          mon_e.port);
                        check("rsp_data",  rdata_o[p], mon_e.data);
                        check("rsp_cycle", cyc,        mon_e.cyc);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni  = 1'b0;
        gap_i   = '0;
        req_i   = '1;
        add_i   = '0;
        wen_i   = '1;
        be_i    = '0;
        wdata_i = '0;

        // ---- reset state (requests asserted must not be granted) ----
        @(negedge clk_i);
        check("reset_gnt",      {24'h0, gnt_o},    32'h0);
        check("reset_rvalid",   {24'h0, rvalid_o}, 32'h0);
        check("reset_rdata",    {31'h0, |rdata_o}, 32'h0);
        check("reset_busy",     {16'h0, busy_cnt_o}, 32'h0);
        tick();
        rst_ni = 1'b1;
        req_i  = '0;

        // ---- single port write then back-to-back read ----
        single(0, 32'h40, 1'b0, 4'hF, 32'hDEADBEEF, 32'h0,        "p0_write_gnt");
        single(0, 32'h40, 1'b1, 4'h0, 32'h0,        32'hDEADBEEF, "p0_read_gnt");

        // ---- preload words 0x40..0x47 from each port; ends with rr_ptr=0 ----
        for (int i = 0; i < NB; i++) begin
            single(i, 32'h100 + 32'(4 * i), 1'b0, 4'hF, 32'h10000000 + 32'(i), 32'h0,
                   "preload_gnt");
        end

        // ---- all ports read at once; aliased addresses with junk high/low bits ----
        req_i = '1;
        wen_i = '1;
        for (int i = 0; i < NB; i++) begin
            add_i[i] = 32'hFFFF0103 + 32'(4 * i);
        end
        for (int c = 0; c < NB; c++) begin
            expect_gnt("rr_all_gnt", 8'(1 << c), c, 32'h10000000 + 32'(c));
            check("rr_all_busy", {16'h0, busy_cnt_o}, 32'h0);
            tick();
            req_i[c] = 1'b0;
        end

        // ---- byte enables ----
        single(0, 32'h80, 1'b0, 4'hF,    32'h11223344, 32'h0,        "be_pre_gnt");
        single(0, 32'h80, 1'b0, 4'b0101, 32'hAABBCCDD, 32'h0,        "be_wr_gnt");
        single(0, 32'h80, 1'b1, 4'h0,    32'h0,        32'h11BB33DD, "be_rd_gnt");

        // ---- wait states: gap 3, ports 2 and 5 holding requests (rr_ptr=1) ----
        gap_i    = 4'd3;
        req_i    = 8'h24;
        add_i[2] = 32'h108;
        add_i[5] = 32'h114;
        wen_i    = '1;
        expect_gnt("gap_t0_gnt", 8'h04, 2, 32'h10000002);
        check("gap_t0_busy", {16'h0, busy_cnt_o}, 32'd0);
        repeat (3) begin tick(); expect_gnt("gap_stall_a", 8'h00, -1, 32'h0); end
        tick();
        expect_gnt("gap_t4_gnt", 8'h20, 5, 32'h10000005);
        check("gap_t4_busy", {16'h0, busy_cnt_o}, 32'd3);
        repeat (3) begin tick(); expect_gnt("gap_stall_b", 8'h00, -1, 32'h0); end
        tick();
        expect_gnt("gap_t8_gnt", 8'h04, 2, 32'h10000002);
        check("gap_t8_busy", {16'h0, busy_cnt_o}, 32'd6);
        // gap_i drops while counting: the running gap is unaffected.
        tick();
        gap_i = 4'd0;
        expect_gnt("gap_stall_c", 8'h00, -1, 32'h0);
        repeat (2) begin tick(); expect_gnt("gap_stall_c", 8'h00, -1, 32'h0); end
        tick();
        expect_gnt("gap_t12_gnt", 8'h20, 5, 32'h10000005);
        check("gap_t12_busy", {16'h0, busy_cnt_o}, 32'd9);
        tick();
        expect_gnt("gap_t13_gnt", 8'h04, 2, 32'h10000002);
        check("gap_t13_busy", {16'h0, busy_cnt_o}, 32'd9);
        tick();
        req_i = '0;

        // ---- wrap fairness: port5 grant leaves rr_ptr=6, then ports 1 and 7 ----
        single(5, 32'h114, 1'b1, 4'h0, 32'h0, 32'h10000005, "wrap_p5_gnt");
        req_i    = 8'h82;
        add_i[1] = 32'h104;
        add_i[7] = 32'h11C;
        expect_gnt("wrap_p7_gnt", 8'h80, 7, 32'h10000007);
        tick();
        req_i[7] = 1'b0;
        expect_gnt("wrap_p1_gnt", 8'h02, 1, 32'h10000001);
        // rr_ptr must now be 2: port 2 beats port 0.
        tick();
        req_i    = 8'h05;
        add_i[0] = 32'h100;
        add_i[2] = 32'h108;
        expect_gnt("wrap_ptr2_gnt", 8'h04, 2, 32'h10000002);
        tick();
        req_i[2] = 1'b0;
        expect_gnt("wrap_p0_gnt", 8'h01, 0, 32'h10000000);
        tick();
        req_i = '0;
        tick();
        @(negedge clk_i);
        check("hold_rvalid", {24'h0, rvalid_o}, 32'h0);
        check("hold_rdata0", rdata_o[0], 32'h10000000);
        tick();

        // ---- async reset the cycle after a read grant (with a gap pending) ----
        gap_i    = 4'd2;
        req_i    = 8'h08;
        add_i[3] = 32'h10C;
        wen_i    = '1;
        expect_gnt("rst_pre_gnt", 8'h08, -1, 32'h0);
        tick();
        rst_ni = 1'b0;
        req_i  = '1;
        gap_i  = 4'd0;
        for (int i = 0; i < NB; i++) begin
            add_i[i] = 32'h40;
        end
        repeat (2) begin
            @(negedge clk_i);
            check("rst_mid_gnt",    {24'h0, gnt_o},      32'h0);
            check("rst_mid_rvalid", {24'h0, rvalid_o},   32'h0);
            check("rst_mid_rdata3", rdata_o[3],          32'h0);
            check("rst_mid_busy",   {16'h0, busy_cnt_o}, 32'h0);
            tick();
        end
        rst_ni = 1'b1;
        expect_gnt("post_rst_gnt", 8'h01, 0, 32'hDEADBEEF);
        tick();
        req_i = '0;
        repeat (3) tick();

        check("sb_drained", sb_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
